// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, word geometry and default oversample rate.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam int DATA_BITS      = 8;
  localparam int WORD_W         = 9;
  localparam int OVERSAMPLE_DEF = 16;
endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchronizer and bit-decision filter. With UART_RX_MAJORITY_EN the decision is a
// 2-of-3 vote over the last three baud ticks; otherwise it is the synchronized level itself.
module uart_rx_sampler (
  input  logic clk,
  input  logic reset,
`ifdef UART_RX_MAJORITY_EN
  input  logic baud_tick,
`endif
  input  logic rx,
  output logic rx_s,
  output logic bit_val
);
  logic rx_m;

  // Idle-high reset keeps a reset release from looking like a start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (reset)          hist <= 2'b11;
    else if (baud_tick) hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif
endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start/8 data/parity/stop, writes {parity, data} to the RX FIFO.
// Optional majority voting of bit samples is enabled by UART_RX_MAJORITY_EN.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic              rx,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [WORD_W-1:0] fifo_din,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [2:0]             bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0]   data, data_n;
  logic                   par, par_n;
  logic [WORD_W-1:0]      din_n;
  logic                   frame_ok, frame_ok_n, pe_n, fe_n;
  logic                   rx_s, bit_val;

  uart_rx_sampler u_sampler (
    .clk       (clk),
    .reset     (reset),
`ifdef UART_RX_MAJORITY_EN
    .baud_tick (baud_tick),
`endif
    .rx        (rx),
    .rx_s      (rx_s),
    .bit_val   (bit_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data       <= '0;
      par        <= 1'b0;
      fifo_din   <= '0;
      frame_ok   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      data       <= data_n;
      par        <= par_n;
      fifo_din   <= din_n;
      frame_ok   <= frame_ok_n;
      parity_err <= pe_n;
      frame_err  <= fe_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    data_n     = data;
    par_n      = par;
    din_n      = fifo_din;
    frame_ok_n = 1'b0;
    pe_n       = 1'b0;
    fe_n       = 1'b0;
    if (baud_tick) begin
      case (state)
        IDLE: if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
        START: if (cnt == HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = bit_val ? IDLE : DATA;
        end else cnt_n = cnt + 1'b1;
        DATA: if (cnt == FULL) begin
          cnt_n           = '0;
          data_n[bit_idx] = bit_val;
          if (bit_idx == 3'd7) state_n = PARITY;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else cnt_n = cnt + 1'b1;
        PARITY: if (cnt == FULL) begin
          cnt_n   = '0;
          par_n   = bit_val;
          state_n = STOP;
        end else cnt_n = cnt + 1'b1;
        STOP: if (cnt == FULL) begin
          cnt_n = '0;
          if (bit_val) begin
            din_n      = {par, data};
            frame_ok_n = 1'b1;
            pe_n       = par ^ (^data) ^ PARITY_ODD;
            state_n    = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = BREAK;
          end
        end else cnt_n = cnt + 1'b1;
        BREAK: if (rx_s) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // fifo_full is judged in the cycle the write is presented, not at the stop sample
  assign fifo_wr_en  = frame_ok & ~fifo_full;
  assign overrun_err = frame_ok & fifo_full;
  assign busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed self-checking bench for uart_rx_deframer (OVERSAMPLE=16, even parity, baud_tick=1).
module tb_uart_rx_deframer;
  logic       clk = 1'b0;
  logic       reset, baud_tick, rx, fifo_full;
  logic       fifo_wr_en, parity_err, frame_err, overrun_err, busy;
  logic [8:0] fifo_din;

  int passed = 0, total = 0;
  int wr_cnt = 0, pe_cnt = 0, pe_wr_cnt = 0, fe_cnt = 0, oe_cnt = 0;

  uart_rx_deframer #(.OVERSAMPLE(16), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr_en) wr_cnt++;
    if (parity_err) pe_cnt++;
    if (parity_err && fifo_wr_en) pe_wr_cnt++;
    if (frame_err) fe_cnt++;
    if (overrun_err) oe_cnt++;
  end

  task automatic hold_bit(input logic b);
    repeat (16) begin
      rx = b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    hold_bit(p);
    hold_bit(stp);
  endtask

  task automatic test_reset;
    reset = 1'b1; rx = 1'b1; baud_tick = 1'b1; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); else passed++;
    total++; if (fifo_din !== 9'h000) $display("FAIL reset_din got %h want 000", fifo_din); else passed++;
    total++; if ({parity_err, frame_err, overrun_err} !== 3'b000)
      $display("FAIL reset_errs got %b want 000", {parity_err, frame_err, overrun_err}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame;
    int w0 = wr_cnt, e0 = pe_cnt + fe_cnt + oe_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    total++; if (wr_cnt - w0 !== 1) $display("FAIL good_wr_count got %0d want 1", wr_cnt - w0); else passed++;
    total++; if (fifo_din !== 9'h0A5) $display("FAIL good_din got %h want 0a5", fifo_din); else passed++;
    total++; if (pe_cnt + fe_cnt + oe_cnt - e0 !== 0)
      $display("FAIL good_no_err got %0d want 0", pe_cnt + fe_cnt + oe_cnt - e0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL good_busy got %b want 0", busy); else passed++;
    hold_bit(1'b1);
  endtask

  task automatic test_parity_err;
    int w0 = wr_cnt, p0 = pe_wr_cnt, pa = pe_cnt;
    send_frame(8'h5A, 1'b1, 1'b1);
    total++; if (wr_cnt - w0 !== 1) $display("FAIL par_wr_count got %0d want 1", wr_cnt - w0); else passed++;
    total++; if (fifo_din !== 9'h15A) $display("FAIL par_din got %h want 15a", fifo_din); else passed++;
    total++; if (pe_wr_cnt - p0 !== 1 || pe_cnt - pa !== 1)
      $display("FAIL par_err_with_wr got %0d/%0d want 1/1", pe_wr_cnt - p0, pe_cnt - pa); else passed++;
    hold_bit(1'b1);
  endtask

  task automatic test_frame_err;
    int w0 = wr_cnt, f0 = fe_cnt, p0 = pe_cnt;
    logic [8:0] d0 = fifo_din;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) begin rx = 1'b0; @(negedge clk); end
    total++; if (fe_cnt - f0 !== 1) $display("FAIL fe_count got %0d want 1", fe_cnt - f0); else passed++;
    total++; if (wr_cnt - w0 !== 0 || pe_cnt - p0 !== 0)
      $display("FAIL fe_no_write got wr=%0d pe=%0d want 0/0", wr_cnt - w0, pe_cnt - p0); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL fe_break_busy got %b want 1", busy); else passed++;
    total++; if (fifo_din !== d0) $display("FAIL fe_din_held got %h want %h", fifo_din, d0); else passed++;
    repeat (5) begin rx = 1'b1; @(negedge clk); end
    total++; if (busy !== 1'b0) $display("FAIL fe_break_exit got %b want 0", busy); else passed++;
    hold_bit(1'b1);
  endtask

  task automatic test_overrun;
    int w0 = wr_cnt, o0 = oe_cnt;
    fifo_full = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1);
    total++; if (wr_cnt - w0 !== 0) $display("FAIL ovr_no_write got %0d want 0", wr_cnt - w0); else passed++;
    total++; if (oe_cnt - o0 !== 1) $display("FAIL ovr_err got %0d want 1", oe_cnt - o0); else passed++;
    total++; if (fifo_din !== 9'h081) $display("FAIL ovr_din got %h want 081", fifo_din); else passed++;
    hold_bit(1'b1);
    fifo_full = 1'b0;
    w0 = wr_cnt;
    send_frame(8'h7E, 1'b0, 1'b1);
    total++; if (wr_cnt - w0 !== 1 || oe_cnt - o0 !== 1)
      $display("FAIL ovr_next got wr=%0d oe=%0d want 1/1", wr_cnt - w0, oe_cnt - o0); else passed++;
    total++; if (fifo_din !== 9'h07E) $display("FAIL ovr_next_din got %h want 07e", fifo_din); else passed++;
    hold_bit(1'b1);
  endtask

  task automatic test_glitch;
    int w0 = wr_cnt, e0 = pe_cnt + fe_cnt + oe_cnt;
    logic saw_busy = 1'b0;
    repeat (4) begin rx = 1'b0; @(negedge clk); end
    repeat (20) begin rx = 1'b1; @(negedge clk); if (busy) saw_busy = 1'b1; end
    total++; if (saw_busy !== 1'b1) $display("FAIL glitch_start_seen got %b want 1", saw_busy); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy got %b want 0", busy); else passed++;
    total++; if (wr_cnt - w0 !== 0 || pe_cnt + fe_cnt + oe_cnt - e0 !== 0)
      $display("FAIL glitch_quiet got wr=%0d err=%0d want 0/0", wr_cnt - w0, pe_cnt + fe_cnt + oe_cnt - e0);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int w0 = wr_cnt;
    send_frame(8'h11, 1'b0, 1'b1);
    total++; if (fifo_din !== 9'h011) $display("FAIL b2b_first_din got %h want 011", fifo_din); else passed++;
    send_frame(8'h22, 1'b0, 1'b1);
    total++; if (fifo_din !== 9'h022) $display("FAIL b2b_second_din got %h want 022", fifo_din); else passed++;
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b0);
    hold_bit(1'b1);
    reset = 1'b1; rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0)
      $display("FAIL b2b_reset_ctl got busy=%b wr=%b want 0/0", busy, fifo_wr_en); else passed++;
    total++; if (fifo_din !== 9'h000) $display("FAIL b2b_reset_din got %h want 000", fifo_din); else passed++;
    repeat (200) @(negedge clk);
    total++; if (wr_cnt - w0 !== 2) $display("FAIL b2b_write_count got %0d want 2", wr_cnt - w0); else passed++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial-to-parallel UART receive stage that sits directly upstream of the RX FIFO.
- Oversamples the asynchronous rx line and detects start bits.
- Shifts in 8 data bits LSB-first, then the parity bit, then checks the stop bit.
- Writes each good frame as a 9-bit word {parity_bit, data[7:0]} into the FIFO write port, with per-frame error pulses for the status logic.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and >= 8.
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- baud_tick  input  1  oversample strobe, one clk wide, rate = OVERSAMPLE x baud.
- rx  input  1  asynchronous serial line; idles high.
- fifo_full  input  1  RX FIFO full flag.
- fifo_wr_en  output  1  one-clk write strobe to the RX FIFO.
- fifo_din  output  9  {received parity bit, data[7:0]}.
- parity_err  output  1  one-clk pulse: received parity bit mismatches computed parity.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun_err  output  1  one-clk pulse: good frame dropped because fifo_full.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset: state=IDLE. fifo_wr_en, parity_err, frame_err, overrun_err and busy = 0. fifo_din = 0. Synchronizer flops = 1. Tick counter and bit index = 0.
- Input conditioning: rx passes through a 2-flop synchronizer, giving rx_s. All decisions use rx_s.
- Timing: the counter advances only on baud_tick cycles. baud_tick held at 1 is legal, giving OVERSAMPLE clks per bit.
- IDLE: on a tick with rx_s=0, go to START with cnt=0.
- START: on the tick where cnt reaches OVERSAMPLE/2-1 (start mid-bit):
  - sample=0 -> DATA, cnt=0, bit_idx=0;
  - sample=1 -> IDLE (glitch rejected, no error flagged).
- DATA: sample at cnt=OVERSAMPLE-1 (mid-bit), then cnt=0. Sample goes into data[bit_idx], LSB first. After bit_idx=7 -> PARITY.
- PARITY: sample the parity bit at mid-bit -> STOP.
- STOP: sample at mid-bit, then:
  - Sample=1: frame is good. Next clk: fifo_din={par,data}.
    - If fifo_full=0: fifo_wr_en=1.
    - Else: fifo_wr_en stays 0 and overrun_err=1.
    - parity_err=1 in the same cycle if par != (^data ^ PARITY_ODD); the word is still written.
    - Go to IDLE immediately, so the next start bit is detectable at once.
  - Sample=0: frame_err=1 next clk; no write; parity_err not flagged. Go to BREAK.
- BREAK: wait until rx_s=1 on a tick, then go to IDLE. This prevents a held-low line from retriggering starts.
- Latency: the write strobe comes 1 clk after the stop-bit sample tick. fifo_din stays stable until the next frame completes.
- Reset mid-frame: frame is aborted and discarded, no strobe or error is output, return to IDLE.
- fifo_full is sampled in the same cycle the write is issued.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit decision, including start validation, is the 2-of-3 majority of rx_s on the three ticks ending at the mid-bit tick. The start bit still needs majority=0.
- Not defined: single sample of rx_s at the mid-bit tick.
- Frame timing and latency are identical either way.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - DATA_BITS=8, WORD_W=9;
  - default OVERSAMPLE shared with the TX side.
- Sub-module uart_rx_sampler: 2-flop synchronizer plus the optional majority filter, producing rx_s and the bit decision.
- The FSM, counters and shift register stay in the top module.

Test Plan (all with baud_tick=1, OVERSAMPLE=16, PARITY_ODD=0):
- Frame 0xA5, parity 0, stop 1, fifo_full=0 -> one fifo_wr_en pulse, fifo_din=9'h0A5, no error pulses, busy low after the stop sample.
- Frame 0x5A with parity bit 1 -> fifo_wr_en pulse, fifo_din=9'h15A, parity_err pulse in the same clk.
- Frame 0x3C, stop bit 0, rx then held low for 40 clks, then high -> frame_err pulse, no write, no new frame until rx returns high.
- Frame 0x81 with fifo_full=1 -> no fifo_wr_en, overrun_err pulse. The next frame 0x7E with fifo_full=0 -> fifo_din=9'h07E.
- rx low for 4 clks from idle -> no frame, no errors, busy returns to 0.
- Back-to-back frames 0x11 then 0x22 with no idle gap, and reset asserted mid-data of a third frame -> exactly two writes, no third write, and reset values are present one clk after reset.
